// File: rtl/sensor_adc_sequencer.sv
// Power/settle/strobe/capture sequencer for the radiation sensor and its ADC.
// Build option SENSOR_ADC_SEQ_AVERAGE_EN: average four conversions per measurement.
module sensor_adc_sequencer #(
    parameter int unsigned SENS_SETTLE_TICKS = 64,
    parameter int unsigned ADC_SETTLE_TICKS  = 32,
    parameter int unsigned TIMEOUT_TICKS     = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [2:0]  cfg,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] result,
    output logic [2:0]  sens_config,
    output logic        sens_enable,
    output logic        sens_read,
    output logic        adc_enable,
    output logic        adc_read,
    input  logic        adc_conversion_complete,
    input  logic [15:0] adc_value
);
    localparam logic [15:0] SENS_LOAD    = 16'(SENS_SETTLE_TICKS - 1);
    localparam logic [15:0] ADC_LOAD     = 16'(ADC_SETTLE_TICKS - 1);
    localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SENS_SETTLE,
        ADC_SETTLE,
        READ,
        WAIT_CONV,
        FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [15:0] result_q, result_d;
    logic [2:0]  sens_config_q, sens_config_d;
    logic        sens_enable_q, sens_enable_d;
    logic        adc_enable_q, adc_enable_d;
    logic        read_q, read_d;
`ifdef SENSOR_ADC_SEQ_AVERAGE_EN
    logic [1:0]  nsamp_q, nsamp_d;
    logic [17:0] acc_q, acc_d;
    logic [17:0] acc_sum;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        error_d       = error_q;
        result_d      = result_q;
        sens_config_d = sens_config_q;
`ifdef SENSOR_ADC_SEQ_AVERAGE_EN
        nsamp_d = nsamp_q;
        acc_d   = acc_q;
        acc_sum = acc_q + {2'b00, adc_value};
`endif
        // Abort takes priority over everything, including a same-cycle capture.
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        sens_config_d = cfg;
                        error_d       = 1'b0;
                        cnt_d         = SENS_LOAD;
                        state_d       = SENS_SETTLE;
`ifdef SENSOR_ADC_SEQ_AVERAGE_EN
                        nsamp_d = '0;
                        acc_d   = '0;
`endif
                    end
                end
                SENS_SETTLE: begin
                    if (cnt_q == '0) begin
                        cnt_d   = ADC_LOAD;
                        state_d = ADC_SETTLE;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                ADC_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = READ;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                READ: begin
                    cnt_d   = TIMEOUT_LOAD;
                    state_d = WAIT_CONV;
                end
                WAIT_CONV: begin
                    if (adc_conversion_complete) begin
`ifdef SENSOR_ADC_SEQ_AVERAGE_EN
                        if (nsamp_q == 2'd3) begin
                            result_d = acc_sum[17:2];
                            state_d  = FINISH;
                        end else begin
                            acc_d   = acc_sum;
                            nsamp_d = nsamp_q + 2'd1;
                            state_d = READ;
                        end
`else
                        result_d = adc_value;
                        state_d  = FINISH;
`endif
                    end else if (cnt_q == '0) begin
                        error_d = 1'b1;
                        state_d = FINISH;
`ifdef SENSOR_ADC_SEQ_AVERAGE_EN
                        nsamp_d = '0;
                        acc_d   = '0;
`endif
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                FINISH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they register alongside it.
        busy_d        = (state_d != IDLE);
        done_d        = (state_d == FINISH);
        read_d        = (state_d == READ);
        adc_enable_d  = (state_d == ADC_SETTLE) || (state_d == READ) || (state_d == WAIT_CONV);
        sens_enable_d = adc_enable_d || (state_d == SENS_SETTLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            result_q      <= '0;
            sens_config_q <= '0;
            sens_enable_q <= 1'b0;
            adc_enable_q  <= 1'b0;
            read_q        <= 1'b0;
`ifdef SENSOR_ADC_SEQ_AVERAGE_EN
            nsamp_q <= '0;
            acc_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            result_q      <= result_d;
            sens_config_q <= sens_config_d;
            sens_enable_q <= sens_enable_d;
            adc_enable_q  <= adc_enable_d;
            read_q        <= read_d;
`ifdef SENSOR_ADC_SEQ_AVERAGE_EN
            nsamp_q <= nsamp_d;
            acc_q   <= acc_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign result      = result_q;
    assign sens_config = sens_config_q;
    assign sens_enable = sens_enable_q;
    assign adc_enable  = adc_enable_q;
    assign sens_read   = read_q;
    assign adc_read    = read_q;
endmodule

// File: tb/tb_sensor_adc_sequencer.sv
// Bench for sensor_adc_sequencer: table vectors, randomized measurements against a
// timeline model, and hand-written abort / ignored-start sequences.
module tb_sensor_adc_sequencer;
    localparam int S = 64;
    localparam int A = 32;
    localparam int T = 4096;
`ifdef SENSOR_ADC_SEQ_AVERAGE_EN
    localparam int K = 4;
`else
    localparam int K = 1;
`endif

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [2:0]  cfg;
    logic        busy, done, error;
    logic [15:0] result;
    logic [2:0]  sens_config;
    logic        sens_enable, sens_read, adc_enable, adc_read;
    logic        adc_conversion_complete;
    logic [15:0] adc_value;

    always #5 clk = ~clk;

    sensor_adc_sequencer #(
        .SENS_SETTLE_TICKS(S),
        .ADC_SETTLE_TICKS (A),
        .TIMEOUT_TICKS    (T)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .start                  (start),
        .abort                  (abort),
        .cfg                    (cfg),
        .busy                   (busy),
        .done                   (done),
        .error                  (error),
        .result                 (result),
        .sens_config            (sens_config),
        .sens_enable            (sens_enable),
        .sens_read              (sens_read),
        .adc_enable             (adc_enable),
        .adc_read               (adc_read),
        .adc_conversion_complete(adc_conversion_complete),
        .adc_value              (adc_value)
    );

    typedef struct packed {
        logic [2:0]        cfg;
        logic [3:0][12:0]  d;     // low cycles in WAIT_CONV before complete; T = never
        logic [3:0][15:0]  v;
        int                lat;   // start edge to done, in cycles
        logic              err;
        logic [15:0]       res;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] res_model = '0;
    logic        err_model = 1'b0;
    logic [2:0]  cfg_model = '0;
    vec_t        tbl[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [25:0] pack(input logic b, input logic d, input logic e,
                                         input logic se, input logic ae, input logic sr,
                                         input logic ar, input logic [2:0] c, input logic [15:0] r);
        return {b, d, e, se, ae, sr, ar, c, r};
    endfunction

    function automatic logic [25:0] dut_vec();
        return pack(busy, done, error, sens_enable, adc_enable, sens_read, adc_read,
                    sens_config, result);
    endfunction

    function automatic vec_t mk(input logic [2:0] c, input int d0, input int d1, input int d2,
                                input int d3, input logic [15:0] v0, input logic [15:0] v1,
                                input logic [15:0] v2, input logic [15:0] v3, input int lat,
                                input logic err, input logic [15:0] res);
        vec_t m;
        m.cfg  = c;
        m.d[0] = 13'(d0); m.d[1] = 13'(d1); m.d[2] = 13'(d2); m.d[3] = 13'(d3);
        m.v[0] = v0;      m.v[1] = v1;      m.v[2] = v2;      m.v[3] = v3;
        m.lat  = lat;
        m.err  = err;
        m.res  = res;
        return m;
    endfunction

    // One measurement; expected outputs each cycle come from the strobe/complete timeline.
    task automatic run_meas(input logic [2:0] c, input logic [3:0][12:0] dl,
                            input logic [3:0][15:0] vl, input bit noise,
                            output int act_lat, output logic act_err, output logic [15:0] act_res);
        int sr[4], rc[4], wend[4];
        int d_r, r0, sum;
        bit terr, is_sr, in_wait, hit;
        logic [15:0] new_res, hit_v;
        terr = 0; sum = 0; d_r = 0; r0 = S + A + 1;
        for (int i = 0; i < 4; i++) begin
            sr[i] = -1; rc[i] = -1; wend[i] = -1;
        end
        for (int i = 0; i < K; i++) begin
            if (d_r == 0) begin
                sr[i] = r0;
                if (int'(dl[i]) < T) begin
                    rc[i]   = r0 + 1 + int'(dl[i]);
                    wend[i] = rc[i];
                    sum    += int'(vl[i]);
                    if (i == K - 1) d_r = rc[i] + 1;
                    else            r0  = rc[i] + 1;
                end else begin
                    wend[i] = r0 + T;
                    d_r     = r0 + T + 1;
                    terr    = 1;
                end
            end
        end
        new_res = terr ? res_model : 16'(sum / K);

        cfg = c; start = 1'b1; abort = 1'b0;
        adc_conversion_complete = 1'b0; adc_value = 16'($urandom);
        step();
        act_lat = -1; act_err = 1'b0; act_res = '0;
        for (int r = 1; r <= d_r + 1; r++) begin
            is_sr = 0; in_wait = 0; hit = 0; hit_v = '0;
            for (int i = 0; i < 4; i++) begin
                if (sr[i] == r) is_sr = 1;
                if (sr[i] >= 0 && r > sr[i] && r <= wend[i]) in_wait = 1;
                if (rc[i] == r) begin hit = 1; hit_v = vl[i]; end
            end
            check($sformatf("cycle r=%0d", r), 32'(dut_vec()),
                  32'(pack(r <= d_r, r == d_r, (r >= d_r) ? terr : 1'b0, r < d_r,
                           (r > S) && (r < d_r), is_sr, is_sr, c,
                           (r >= d_r) ? new_res : res_model)));
            if (done && act_lat < 0) begin
                act_lat = r; act_err = error; act_res = result;
            end
            start = (noise && r <= d_r) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (hit) begin
                adc_conversion_complete = 1'b1;
                adc_value = hit_v;
            end else begin
                adc_conversion_complete = (noise && !in_wait) ? 1'($urandom_range(0, 1)) : 1'b0;
                adc_value = 16'($urandom);
            end
            step();
        end
        adc_conversion_complete = 1'b0;
        res_model = new_res;
        err_model = terr;
        cfg_model = c;
    endtask

    initial begin
        int          lat;
        logic        e;
        logic [15:0] res;
        logic [3:0][12:0] dl;
        logic [3:0][15:0] vl;

`ifdef SENSOR_ADC_SEQ_AVERAGE_EN
        tbl.push_back(mk(3'b101, 1, 2, 0, 3, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0002,
                         111, 1'b0, 16'h8000));
        tbl.push_back(mk(3'b110, 0, 0, T, 0, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
                         4198, 1'b1, 16'h8000));
        tbl.push_back(mk(3'b011, 0, 0, 0, T - 1, 16'h0004, 16'h0008, 16'h000C, 16'h0010,
                         4200, 1'b0, 16'h000A));
`else
        tbl.push_back(mk(3'b101, 10, 0, 0, 0, 16'h1234, 0, 0, 0, 109, 1'b0, 16'h1234));
        tbl.push_back(mk(3'b111, T, 0, 0, 0, 16'hDEAD, 0, 0, 0, 4194, 1'b1, 16'h1234));
        tbl.push_back(mk(3'b001, T - 1, 0, 0, 0, 16'h5A5A, 0, 0, 0, 4194, 1'b0, 16'h5A5A));
        tbl.push_back(mk(3'b010, 0, 0, 0, 0, 16'hABCD, 0, 0, 0, 99, 1'b0, 16'hABCD));
        tbl.push_back(mk(3'b000, 3, 0, 0, 0, 16'h0000, 0, 0, 0, 102, 1'b0, 16'h0000));
`endif

        rst = 1'b1; start = 1'b0; abort = 1'b0; cfg = '0;
        adc_conversion_complete = 1'b0; adc_value = '0;
        step(); step();
        check("reset", 32'(dut_vec()), 32'(0));
        rst = 1'b0;
        step();

        foreach (tbl[i]) begin
            run_meas(tbl[i].cfg, tbl[i].d, tbl[i].v, 1'b1, lat, e, res);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].lat));
            check($sformatf("vec%0d error", i), 32'(e), 32'(tbl[i].err));
            check($sformatf("vec%0d result", i), 32'(res), 32'(tbl[i].res));
            check($sformatf("vec%0d sens_config", i), 32'(sens_config), 32'(tbl[i].cfg));
        end

        // Abort during ADC_SETTLE, then a normal measurement.
        cfg = 3'b011; start = 1'b1; step(); start = 1'b0;
        err_model = 1'b0; cfg_model = 3'b011;
        for (int r = 1; r < S + 5; r++) step();
        check("adc_settle reached", 32'(adc_enable), 32'(1));
        abort = 1'b1; step(); abort = 1'b0;
        for (int r = 0; r < 20; r++) begin
            check($sformatf("after abort %0d", r), 32'(dut_vec()),
                  32'(pack(0, 0, 0, 0, 0, 0, 0, cfg_model, res_model)));
            step();
        end
        dl = '0; vl = '0; vl[0] = 16'h0F0F; vl[1] = 16'h0F0F; vl[2] = 16'h0F0F; vl[3] = 16'h0F0F;
        run_meas(3'b100, dl, vl, 1'b0, lat, e, res);
        check("post-abort result", 32'(res), 32'(16'h0F0F));

        // Abort in WAIT_CONV coinciding with completion: no capture, no done.
        cfg = 3'b110; start = 1'b1; step(); start = 1'b0;
        err_model = 1'b0; cfg_model = 3'b110;
        for (int r = 1; r < S + A + 3; r++) step();
        abort = 1'b1; adc_conversion_complete = 1'b1; adc_value = 16'hFFFF;
        step();
        abort = 1'b0; adc_conversion_complete = 1'b0;
        check("abort wins over complete", 32'(dut_vec()),
              32'(pack(0, 0, 0, 0, 0, 0, 0, cfg_model, res_model)));

        // start together with abort in IDLE is ignored.
        cfg = 3'b001; start = 1'b1; abort = 1'b1; step();
        start = 1'b0; abort = 1'b0;
        check("start+abort idle", 32'(dut_vec()),
              32'(pack(0, 0, err_model, 0, 0, 0, 0, cfg_model, res_model)));
        step();
        check("start+abort idle next", 32'(dut_vec()),
              32'(pack(0, 0, err_model, 0, 0, 0, 0, cfg_model, res_model)));

        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 4; i++) begin
                dl[i] = ($urandom_range(0, 9) == 0) ? 13'(T) : 13'($urandom_range(0, 40));
                vl[i] = 16'($urandom);
            end
            run_meas(3'($urandom), dl, vl, 1'b1, lat, e, res);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sensor_adc_sequencer.md
# sensor_adc_sequencer

Sequences the radiation sensor and ADC for a single measurement: powers the sensor, lets it settle, powers the ADC, lets it settle, issues a read strobe, waits for conversion complete and captures the 16-bit result. Sits between the 14443-4 application adapter (which issues measurement requests) and the sensor/ADC pins of the digital top. It replaces ad-hoc pin toggling with one request/done handshake, plus timeout and abort handling.

## Interface
Parameters:
- SENS_SETTLE_TICKS, 64, clk cycles from sens_enable rising to adc_enable rising; legal range 1..65535
- ADC_SETTLE_TICKS, 32, clk cycles from adc_enable rising to the read strobe; legal range 1..65535
- TIMEOUT_TICKS, 4096, max clk cycles spent waiting for adc_conversion_complete after each read strobe; legal range 1..65535

Ports:
- clk  in  1  13.56MHz carrier-recovered clock; the only clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a measurement; honoured only in IDLE
- abort  in  1  cancel any measurement in progress
- cfg  in  3  sensor configuration, latched on an accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; result/error are valid while it is high
- error  out  1  set with done when a timeout occurred; held until the next accepted start
- result  out  16  captured (or averaged) ADC value; held until the next done
- sens_config  out  3  latched cfg
- sens_enable  out  1  sensor power enable
- sens_read  out  1  one-cycle sensor read strobe
- adc_enable  out  1  ADC power enable
- adc_read  out  1  one-cycle ADC read strobe; coincident with sens_read
- adc_conversion_complete  in  1  synchronous level from the ADC
- adc_value  in  16  ADC output, valid while adc_conversion_complete is high

## Operation
- States: IDLE, SENS_SETTLE, ADC_SETTLE, READ, WAIT_CONV, FINISH. A single 16-bit down-counter serves all timed states.
- IDLE: start=1 and abort=0 → latch cfg into sens_config, clear error, load counter with SENS_SETTLE_TICKS-1, go to SENS_SETTLE.
- SENS_SETTLE: sens_enable=1. When the counter is 0, load ADC_SETTLE_TICKS-1 and go to ADC_SETTLE.
- ADC_SETTLE: sens_enable=1, adc_enable=1. When the counter is 0, go to READ.
- READ (one cycle): sens_read=1, adc_read=1. Load TIMEOUT_TICKS-1 and go to WAIT_CONV.
- WAIT_CONV: adc_conversion_complete=1 → capture adc_value and go to FINISH. Otherwise, when the counter is 0 → set error, leave result unchanged, go to FINISH.
- FINISH (one cycle): done=1. Both enables low. Go to IDLE.
- adc_conversion_complete is ignored outside WAIT_CONV.
- start while busy is ignored; it is not queued.
- abort in any non-IDLE state → IDLE on the next cycle, with both enables and both strobes low. There is no done pulse, and error and result are unchanged.
- abort and start in the same cycle in IDLE → start is ignored.
- Completion and timeout expiry in the same cycle → completion wins: value is captured and error=0.
- sens_config holds its value after the measurement ends.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0.
- All outputs are registered.
- start sampled at edge 0 → busy and sens_enable high from cycle 1.
- adc_enable rises SENS_SETTLE_TICKS cycles after sens_enable rises.
- The read strobe rises ADC_SETTLE_TICKS cycles after adc_enable rises.
- adc_conversion_complete sampled high at edge k → done, updated result, and enables low in cycle k+1; busy low in cycle k+2.
- Timeout: done/error are asserted TIMEOUT_TICKS+1 cycles after the read strobe cycle.
- Minimum start-to-done latency is SENS_SETTLE_TICKS+ADC_SETTLE_TICKS+3 cycles.

## Configuration
- SENSOR_ADC_SEQ_AVERAGE_EN defined: four conversions are performed per measurement.
  - After each capture, if fewer than 4 samples have been taken, go back to READ; the enables stay high and there is no re-settle.
  - Samples accumulate in an 18-bit zero-extended sum; result = sum[17:2] (truncating divide by 4).
  - A timeout on any sample ends the measurement with error=1, leaves result unchanged, and discards the accumulator.
  - The sample counter and accumulator clear on an accepted start.
- SENSOR_ADC_SEQ_AVERAGE_EN undefined: single conversion as described above, and no accumulator logic is present.

## Test plan
- Default parameters, cfg=3'b101, start, ADC returns 16'h1234 with complete 10 cycles after the strobe → done at cycle 64+32+13 after start, result=16'h1234, error=0, sens_config=3'b101.
- Conversion never completes → done and error=1 exactly 4097 cycles after the strobe; result keeps its previous value; both enables low with done.
- abort during ADC_SETTLE → next cycle busy=0 and all enables/strobes low; no done; a following start runs normally.
- start pulsed again during WAIT_CONV, and start+abort together in IDLE → both ignored; exactly one done for the original request.
- Completion on the same cycle the timeout counter reaches 0 → result is captured and error=0.
- With AVERAGE_EN, samples 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0002 → four strobes, result=16'h8000.
